// File: rtl/bram_arbiter_if.sv
// ----------------------------------------------------------------------------
// bram_arbiter_if
// Purpose : request/response bundle between one requester and the bram
//           arbiter. One instance is used per requester port.
// Signals : req    - request, held with we/addr/wdata until gnt
//           we     - write (1) / read (0)
//           addr   - word address
//           wdata  - write data
//           gnt    - request accepted this cycle (combinational)
//           rvalid - read data valid, one-cycle pulse
//           rdata  - read data, holds its last value while rvalid=0
// Modports: master - the requester side
//           slave  - the arbiter side
// ----------------------------------------------------------------------------
interface bram_arbiter_if #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 9
);
    logic                     req;
    logic                     we;
    logic [RAM_ADDR_BITS-1:0] addr;
    logic [RAM_WIDTH-1:0]     wdata;
    logic                     gnt;
    logic                     rvalid;
    logic [RAM_WIDTH-1:0]     rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/bram_arbiter.sv
// ----------------------------------------------------------------------------
// bram_arbiter
// Purpose : shares one single-port synchronous bram between two requesters
//           (A and B). The winning request is registered onto the bram
//           control/address/data inputs; read data comes back two cycles
//           after the grant with a one-cycle valid strobe to the issuer.
// Ports   : clock        - system clock, rising edge
//           reset        - asynchronous, active-high
//           a_port       - requester A (bram_arbiter_if.slave)
//           b_port       - requester B (bram_arbiter_if.slave)
//           ram_enable   - to bram enable
//           write_enable - to bram write enable
//           address      - to bram address
//           input_data   - to bram write data
//           output_data  - from bram read data
// Config  : BRAM_ARB_FIXED_PRIORITY_EN - when defined, A always wins
//           contention; otherwise contention is resolved round-robin.
// ----------------------------------------------------------------------------
module bram_arbiter #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 9
) (
    input  logic                     clock,
    input  logic                     reset,
    bram_arbiter_if.slave            a_port,
    bram_arbiter_if.slave            b_port,
    output logic                     ram_enable,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    output logic [RAM_WIDTH-1:0]     input_data,
    input  logic [RAM_WIDTH-1:0]     output_data
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    logic                     grant_a;
    logic                     grant_b;
    port_e                    last_grant_q, last_grant_d;
    logic                     ram_enable_q, ram_enable_d;
    logic                     write_enable_q, write_enable_d;
    logic [RAM_ADDR_BITS-1:0] address_q, address_d;
    logic [RAM_WIDTH-1:0]     input_data_q, input_data_d;
    logic                     issue_valid_q, issue_valid_d;
    port_e                    issue_owner_q, issue_owner_d;
    logic                     rd_valid_q, rd_valid_d;
    port_e                    rd_owner_q, rd_owner_d;
    logic                     a_rvalid, b_rvalid;
    logic [RAM_WIDTH-1:0]     a_rdata_q, a_rdata_d;
    logic [RAM_WIDTH-1:0]     b_rdata_q, b_rdata_d;

    // Grant selection. Grants are suppressed while reset is held so that no
    // requester believes its request was consumed during reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
            grant_a = a_port.req;
            grant_b = b_port.req && !a_port.req;
`else
            if (a_port.req && b_port.req) begin
                // The port that did not win last time gets this one.
                grant_a = (last_grant_q == PORT_B);
                grant_b = (last_grant_q == PORT_A);
            end else begin
                grant_a = a_port.req;
                grant_b = b_port.req;
            end
`endif
        end
    end

    // Issue and return stage next-state. Address/data hold when idle so the
    // bram inputs only toggle on real accesses. Only reads enter the return
    // pipeline; writes have no response.
    always_comb begin
        ram_enable_d   = 1'b0;
        write_enable_d = 1'b0;
        address_d      = address_q;
        input_data_d   = input_data_q;
        issue_valid_d  = 1'b0;
        issue_owner_d  = issue_owner_q;
        last_grant_d   = last_grant_q;
        if (grant_a) begin
            ram_enable_d   = 1'b1;
            write_enable_d = a_port.we;
            address_d      = a_port.addr;
            input_data_d   = a_port.wdata;
            issue_valid_d  = !a_port.we;
            issue_owner_d  = PORT_A;
            last_grant_d   = PORT_A;
        end else if (grant_b) begin
            ram_enable_d   = 1'b1;
            write_enable_d = b_port.we;
            address_d      = b_port.addr;
            input_data_d   = b_port.wdata;
            issue_valid_d  = !b_port.we;
            issue_owner_d  = PORT_B;
            last_grant_d   = PORT_B;
        end

        // Covers the bram's one-cycle read latency.
        rd_valid_d = issue_valid_q;
        rd_owner_d = issue_owner_q;

        a_rvalid  = rd_valid_q && (rd_owner_q == PORT_A);
        b_rvalid  = rd_valid_q && (rd_owner_q == PORT_B);
        // bram output is passed straight through on the valid cycle and
        // captured so rdata keeps that value afterwards.
        a_rdata_d = a_rvalid ? output_data : a_rdata_q;
        b_rdata_d = b_rvalid ? output_data : b_rdata_q;
    end

    // State registers. last_grant resets to B so A wins the first contention.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q   <= PORT_B;
            ram_enable_q   <= 1'b0;
            write_enable_q <= 1'b0;
            address_q      <= '0;
            input_data_q   <= '0;
            issue_valid_q  <= 1'b0;
            issue_owner_q  <= PORT_A;
            rd_valid_q     <= 1'b0;
            rd_owner_q     <= PORT_A;
            a_rdata_q      <= '0;
            b_rdata_q      <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            ram_enable_q   <= ram_enable_d;
            write_enable_q <= write_enable_d;
            address_q      <= address_d;
            input_data_q   <= input_data_d;
            issue_valid_q  <= issue_valid_d;
            issue_owner_q  <= issue_owner_d;
            rd_valid_q     <= rd_valid_d;
            rd_owner_q     <= rd_owner_d;
            a_rdata_q      <= a_rdata_d;
            b_rdata_q      <= b_rdata_d;
        end
    end

    assign a_port.gnt    = grant_a;
    assign b_port.gnt    = grant_b;
    assign a_port.rvalid = a_rvalid;
    assign b_port.rvalid = b_rvalid;
    assign a_port.rdata  = a_rdata_d;
    assign b_port.rdata  = b_rdata_d;

    assign ram_enable    = ram_enable_q;
    assign write_enable  = write_enable_q;
    assign address       = address_q;
    assign input_data    = input_data_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bram_arbiter
// Self-checking bench for bram_arbiter. A behavioural single-port bram with
// one-cycle read latency sits on the bram side. Inputs are driven on the
// falling edge and outputs sampled 1 time unit later, well away from the
// rising edge. A per-cycle vector table covers the main traffic patterns;
// hand-written sequences cover idle, contention priority and reset
// mid-operation.
// ----------------------------------------------------------------------------
module tb_bram_arbiter;

    localparam int W = 32;
    localparam int AB = 9;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ram_enable;
    logic          write_enable;
    logic [AB-1:0] address;
    logic [W-1:0]  input_data;
    logic [W-1:0]  output_data = '0;

    int checks = 0;
    int errors = 0;

    bram_arbiter_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) a_if ();
    bram_arbiter_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) b_if ();

    bram_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
        .clock        (clock),
        .reset        (reset),
        .a_port       (a_if),
        .b_port       (b_if),
        .ram_enable   (ram_enable),
        .write_enable (write_enable),
        .address      (address),
        .input_data   (input_data),
        .output_data  (output_data)
    );

    always #5 clock = ~clock;

    // Behavioural bram: read-first, registered output.
    logic [W-1:0] mem [0:(1<<AB)-1];
    initial begin
        for (int i = 0; i < (1 << AB); i++) mem[i] = '0;
    end
    always @(posedge clock) begin
        if (ram_enable) begin
            if (write_enable) mem[address] <= input_data;
            output_data <= mem[address];
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] timeout");
    end

    typedef struct {
        logic          a_req;
        logic          a_we;
        logic [AB-1:0] a_addr;
        logic [W-1:0]  a_wdata;
        logic          b_req;
        logic          b_we;
        logic [AB-1:0] b_addr;
        logic [W-1:0]  b_wdata;
        logic          e_a_gnt;
        logic          e_b_gnt;
        logic          e_a_rvalid;
        logic [W-1:0]  e_a_rdata;
        logic          e_b_rvalid;
        logic [W-1:0]  e_b_rdata;
        logic          e_ram_enable;
        logic          e_write_enable;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    function automatic vec_t mkv(
        input int ar, input int aw, input int aa, input int ad,
        input int br, input int bw, input int ba, input int bd,
        input int eag, input int ebg, input int earv, input int eard,
        input int ebrv, input int ebrd, input int een, input int ewe);
        vec_t v;
        v.a_req          = 1'(ar);
        v.a_we           = 1'(aw);
        v.a_addr         = AB'(aa);
        v.a_wdata        = W'(ad);
        v.b_req          = 1'(br);
        v.b_we           = 1'(bw);
        v.b_addr         = AB'(ba);
        v.b_wdata        = W'(bd);
        v.e_a_gnt        = 1'(eag);
        v.e_b_gnt        = 1'(ebg);
        v.e_a_rvalid     = 1'(earv);
        v.e_a_rdata      = W'(eard);
        v.e_b_rvalid     = 1'(ebrv);
        v.e_b_rdata      = W'(ebrd);
        v.e_ram_enable   = 1'(een);
        v.e_write_enable = 1'(ewe);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ar, input logic aw, input logic [AB-1:0] aa, input logic [W-1:0] ad,
                         input logic br, input logic bw, input logic [AB-1:0] ba, input logic [W-1:0] bd);
        a_if.req = ar; a_if.we = aw; a_if.addr = aa; a_if.wdata = ad;
        b_if.req = br; b_if.we = bw; b_if.addr = ba; b_if.wdata = bd;
    endtask

    // Advance to the falling edge, apply one cycle of requests, settle.
    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        drive(v.a_req, v.a_we, v.a_addr, v.a_wdata, v.b_req, v.b_we, v.b_addr, v.b_wdata);
        #1;
    endtask

    task automatic checkVector(input vec_t v, input int idx);
        checkOutput($sformatf("row%0d a_gnt", idx), W'(a_if.gnt), W'(v.e_a_gnt));
        checkOutput($sformatf("row%0d b_gnt", idx), W'(b_if.gnt), W'(v.e_b_gnt));
        checkOutput($sformatf("row%0d a_rvalid", idx), W'(a_if.rvalid), W'(v.e_a_rvalid));
        checkOutput($sformatf("row%0d a_rdata", idx), a_if.rdata, v.e_a_rdata);
        checkOutput($sformatf("row%0d b_rvalid", idx), W'(b_if.rvalid), W'(v.e_b_rvalid));
        checkOutput($sformatf("row%0d b_rdata", idx), b_if.rdata, v.e_b_rdata);
        checkOutput($sformatf("row%0d ram_enable", idx), W'(ram_enable), W'(v.e_ram_enable));
        checkOutput($sformatf("row%0d write_enable", idx), W'(write_enable), W'(v.e_write_enable));
    endtask

    logic exp_a_pri [3];
    logic exp_b_pri [3];

    initial begin
        // Columns: a_req a_we a_addr a_wdata | b_req b_we b_addr b_wdata |
        //          a_gnt b_gnt | a_rvalid a_rdata | b_rvalid b_rdata | ram_en we
        vecs[0]  = mkv(1,1,5,50, 0,0,0,0,  1,0, 0,0,  0,0,  0,0); // A write 5=50
        vecs[1]  = mkv(1,0,5,0,  0,0,0,0,  1,0, 0,0,  0,0,  1,1); // A read 5
        vecs[2]  = mkv(0,0,0,0,  0,0,0,0,  0,0, 0,0,  0,0,  1,0);
        vecs[3]  = mkv(0,0,0,0,  0,0,0,0,  0,0, 1,50, 0,0,  0,0); // read returns 50
        vecs[4]  = mkv(0,0,0,0,  1,1,1,10, 0,1, 0,50, 0,0,  0,0); // B preload 1=10
        vecs[5]  = mkv(0,0,0,0,  1,1,2,20, 0,1, 0,50, 0,0,  1,1); // B preload 2=20
        vecs[6]  = mkv(1,0,1,0,  1,0,2,0,  1,0, 0,50, 0,0,  1,1); // contention: A
        vecs[7]  = mkv(1,0,1,0,  1,0,2,0,  0,1, 0,50, 0,0,  1,0); // contention: B
        vecs[8]  = mkv(1,0,1,0,  1,0,2,0,  1,0, 1,10, 0,0,  1,0); // contention: A
        vecs[9]  = mkv(1,0,1,0,  1,0,2,0,  0,1, 0,10, 1,20, 1,0); // contention: B
        vecs[10] = mkv(1,0,1,0,  0,0,0,0,  1,0, 1,10, 0,20, 1,0);
        vecs[11] = mkv(0,0,0,0,  1,1,7,77, 0,1, 0,10, 1,20, 1,0); // B write 7=77
        vecs[12] = mkv(1,0,7,0,  0,0,0,0,  1,0, 1,10, 0,20, 1,1); // A read 7 next cycle
        vecs[13] = mkv(0,0,0,0,  0,0,0,0,  0,0, 0,10, 0,20, 1,0);
        vecs[14] = mkv(0,0,0,0,  0,0,0,0,  0,0, 1,77, 0,20, 0,0); // new data returned
        vecs[15] = mkv(0,0,0,0,  0,0,0,0,  0,0, 0,77, 0,20, 0,0);

`ifdef BRAM_ARB_FIXED_PRIORITY_EN
        exp_a_pri = '{1'b1, 1'b1, 1'b1};
        exp_b_pri = '{1'b0, 1'b0, 1'b0};
`else
        // last grant before this sequence was A, so B goes first.
        exp_a_pri = '{1'b0, 1'b1, 1'b0};
        exp_b_pri = '{1'b1, 1'b0, 1'b1};
`endif

        // Reset state.
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clock);
        @(negedge clock);
        checkOutput("reset ram_enable", W'(ram_enable), 0);
        checkOutput("reset write_enable", W'(write_enable), 0);
        checkOutput("reset address", W'(address), 0);
        checkOutput("reset input_data", input_data, 0);
        checkOutput("reset a_rvalid", W'(a_if.rvalid), 0);
        checkOutput("reset b_rvalid", W'(b_if.rvalid), 0);
        checkOutput("reset a_rdata", a_if.rdata, 0);
        checkOutput("reset b_rdata", b_if.rdata, 0);
        reset = 1'b0;

        // Table-driven traffic.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkVector(vecs[i], i);
        end

        // Ten idle cycles: bram stays disabled, no strobes.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            drive(0, 0, '0, '0, 0, 0, '0, '0);
            #1;
            checkOutput($sformatf("idle%0d ram_enable", i), W'(ram_enable), 0);
            checkOutput($sformatf("idle%0d write_enable", i), W'(write_enable), 0);
            checkOutput($sformatf("idle%0d a_rvalid", i), W'(a_if.rvalid), 0);
            checkOutput($sformatf("idle%0d b_rvalid", i), W'(b_if.rvalid), 0);
        end

        // Sustained contention for three cycles, then B alone.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive(1, 0, 9'd3, '0, 1, 0, 9'd4, '0);
            #1;
            checkOutput($sformatf("pri%0d a_gnt", i), W'(a_if.gnt), W'(exp_a_pri[i]));
            checkOutput($sformatf("pri%0d b_gnt", i), W'(b_if.gnt), W'(exp_b_pri[i]));
        end
        @(negedge clock);
        drive(0, 0, '0, '0, 1, 0, 9'd4, '0);
        #1;
        checkOutput("pri3 a_gnt", W'(a_if.gnt), 0);
        checkOutput("pri3 b_gnt", W'(b_if.gnt), 1);

        // Drain outstanding reads.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive(0, 0, '0, '0, 0, 0, '0, '0);
        end

        // Reset one cycle after an A read grant.
        @(negedge clock);
        drive(1, 0, 9'd5, 32'hDEAD, 0, 0, '0, '0);
        #1;
        checkOutput("rst a_gnt before", W'(a_if.gnt), 1);
        @(negedge clock);
        checkOutput("rst address before", W'(address), 5);
        checkOutput("rst input_data before", input_data, 32'hDEAD);
        drive(1, 0, 9'd6, '0, 1, 0, 9'd6, '0);
        reset = 1'b1;
        #1;
        checkOutput("rst ram_enable", W'(ram_enable), 0);
        checkOutput("rst write_enable", W'(write_enable), 0);
        checkOutput("rst address", W'(address), 0);
        checkOutput("rst input_data", input_data, 0);
        checkOutput("rst a_gnt held", W'(a_if.gnt), 0);
        checkOutput("rst b_gnt held", W'(b_if.gnt), 0);
        checkOutput("rst a_rdata", a_if.rdata, 0);
        @(negedge clock);
        checkOutput("rst a_rvalid", W'(a_if.rvalid), 0);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        reset = 1'b0;
        @(negedge clock);
        #1;
        checkOutput("rst a_rvalid after", W'(a_if.rvalid), 0);
        @(negedge clock);
        drive(1, 0, 9'd1, '0, 1, 0, 9'd2, '0);
        #1;
        checkOutput("post-rst a_gnt", W'(a_if.gnt), 1);
        checkOutput("post-rst b_gnt", W'(b_if.gnt), 0);
        @(negedge clock);
        drive(0, 0, '0, '0, 0, 0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port bram instance between port A and port B.
- Registers the winning request onto the bram control/address/data inputs.
- Tracks the one-cycle synchronous read latency and returns read data with a valid strobe to the requester that issued the read.
- Sits between two masters (e.g. CPU fetch and data path) and one bram.

Parameters:
- RAM_WIDTH, 32, data width of bram words and requester data buses.
- RAM_ADDR_BITS, 9, bram address width.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- a_req  input  1  port A request; held with a_we/a_addr/a_wdata until a_gnt
- a_we  input  1  port A write (1) / read (0)
- a_addr  input  RAM_ADDR_BITS  port A address
- a_wdata  input  RAM_WIDTH  port A write data
- a_gnt  output  1  port A request accepted this cycle (combinational)
- a_rvalid  output  1  port A read data valid, one-cycle pulse
- a_rdata  output  RAM_WIDTH  port A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B
- ram_enable  output  1  to bram ram_enable
- write_enable  output  1  to bram write_enable
- address  output  RAM_ADDR_BITS  to bram address
- input_data  output  RAM_WIDTH  to bram input_data
- output_data  input  RAM_WIDTH  from bram output_data

Behaviour:
- Reset (async, immediate):
  - ram_enable=0, write_enable=0, address=0, input_data=0.
  - a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - Pipeline valid/owner bits cleared.
  - last_grant=B, so A wins the first contention.
- Arbitration (combinational, cycle N):
  - Only a_req: a_gnt=1.
  - Only b_req: b_gnt=1.
  - Both: grant the port that is not last_grant.
  - Neither: no grant.
  - At most one gnt per cycle. gnt is never asserted without the matching req, and never while reset=1.
- Issue stage, posedge ending cycle N:
  - On a grant: ram_enable<=1, write_enable<=we, address<=addr, input_data<=wdata of the winner; last_grant<=winner.
  - Read grants set issue_valid<=1 and issue_owner<=winner.
  - No grant: ram_enable<=0, write_enable<=0, issue_valid<=0; address/input_data hold.
- bram access: bram samples on posedge ending cycle N+1; output_data is valid during cycle N+2.
- Return stage, posedge ending N+1:
  - rd_valid<=issue_valid, rd_owner<=issue_owner.
  - During N+2: {owner}_rvalid=1 and {owner}_rdata=output_data, captured into a hold register.
  - rdata holds its last value when rvalid=0; the other port's rvalid stays 0.
- Latency:
  - Read: grant in cycle N, rvalid in cycle N+2.
  - Write: committed in bram at end of N+1; no response strobe.
- Throughput: one access per cycle, back-to-back. Under continuous contention, grants alternate A, B, A, B.
- Ordering:
  - Reads and writes from the same port complete in grant order.
  - A read granted the cycle after a write to the same address returns the new data.
- Requester rule: req, we, addr and wdata stay stable until gnt; the request is consumed on the gnt cycle. Deasserting req before gnt withdraws it with no side effect.
- Reset mid-operation: in-flight reads are discarded with no rvalid; a write already registered to bram may or may not commit.

Optional Feature:
- Macro BRAM_ARB_FIXED_PRIORITY_EN.
- Defined:
  - Port A always wins contention; last_grant is unused.
  - B is granted only in cycles with a_req=0.
- Undefined: round-robin as above.

Test Plan:
- Reset, then A writes addr 5 = 32'd50 (a_we=1), then A reads addr 5 -> a_gnt one cycle each; a_rvalid two cycles after the read grant with a_rdata=50; b_rvalid stays 0.
- a_req and b_req held together for 4 reads of addr 1 (A) / addr 2 (B), preloaded 10/20 -> grants A, B, A, B on consecutive cycles; rvalid pulses alternate with rdata 10, 20, 10, 20.
- B writes addr 7 = 77 in cycle N, A reads addr 7 in cycle N+1 -> a_rvalid at N+3 with a_rdata=77.
- Reset asserted one cycle after an A read grant -> no a_rvalid; all bram outputs 0 immediately; the first contention after reset grants A.
- With BRAM_ARB_FIXED_PRIORITY_EN, both requesting for 3 cycles -> a_gnt=1 and b_gnt=0 each cycle; b_gnt in the first cycle a_req=0.
- No requests for 10 cycles -> ram_enable=0, write_enable=0, no rvalid pulses.
